// File: rtl/gray_code_pkg.sv
// Shared mode encodings and width-agnostic binary/Gray conversion helpers.
package gray_pkg;

  // Widest code the converter supports; narrower codes are zero-extended
  // into this width, which leaves both conversions unchanged.
  localparam int MAX_W = 16;

  typedef enum logic [1:0] {
    MODE_B2G  = 2'b00,
    MODE_G2B  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Binary to Gray: each bit is the XOR of itself and its upper neighbour.
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: prefix XOR running from the MSB downwards.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_code_if.sv
// Request/result bundle between a requester and the Gray code converter.
interface gray_code_if
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic             in_valid;
  mode_e            mode;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic [WIDTH-1:0] cnt_gray;
  logic             cnt_wrap;

  // Requester side: issues operations, observes results.
  modport master (
    output in_valid,
    output mode,
    output data_in,
    input  data_out,
    input  out_valid,
    input  cnt_gray,
    input  cnt_wrap
  );

  // Converter side.
  modport slave (
    input  in_valid,
    input  mode,
    input  data_in,
    output data_out,
    output out_valid,
    output cnt_gray,
    output cnt_wrap
  );

endinterface

// File: rtl/gray_code_counter.sv
// Gray-sequence counter: binary count register, registered Gray view of it,
// and a one-cycle wrap pulse when an increment rolls all-ones back to zero.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_next,
  output logic [WIDTH-1:0] cnt_gray,
  output logic             cnt_wrap
);

  logic [WIDTH-1:0] cnt_p0;
  logic             wrap_p0;
  logic [WIDTH-1:0] cnt_p1;
  logic [WIDTH-1:0] gray_p1;
  logic             wrap_p1;

  // Stage p0: next count; a load never raises the wrap pulse.
  always_comb begin
    cnt_p0  = cnt_p1;
    wrap_p0 = 1'b0;
    if (load) begin
      cnt_p0 = load_val;
    end else if (step) begin
      cnt_p0  = cnt_p1 + WIDTH'(1);
      wrap_p0 = &cnt_p1;
    end
  end

  // The Gray form of the next count is shared with the top-level result mux.
  assign gray_next = WIDTH'(bin2gray(MAX_W'(cnt_p0)));

  // Stage p1: count, Gray view and wrap pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1  <= '0;
      gray_p1 <= '0;
      wrap_p1 <= 1'b0;
    end else begin
      cnt_p1  <= cnt_p0;
      gray_p1 <= gray_next;
      wrap_p1 <= wrap_p0;
    end
  end

  assign cnt_gray = gray_p1;
  assign cnt_wrap = wrap_p1;

endmodule

// File: rtl/gray_code.sv
// Registered binary/Gray converter with an integrated Gray-sequence counter.
// Every accepted request produces its result one cycle later.
module gray_code
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic        clk,
  input logic        rst,
  gray_code_if.slave bus
);

  logic [WIDTH-1:0] b2g_p0;
  logic [WIDTH-1:0] g2b_p0;
  logic [WIDTH-1:0] gray_next;
  logic [WIDTH-1:0] res_p0;
  logic             step_p0;
  logic             load_p0;
  logic [WIDTH-1:0] data_p1;
  logic             vld_p1;
  logic [WIDTH-1:0] cnt_gray;
  logic             cnt_wrap;

  // Stage p0: both conversions are computed every cycle; the mode picks one.
  assign b2g_p0  = WIDTH'(bin2gray(MAX_W'(bus.data_in)));
  assign g2b_p0  = WIDTH'(gray2bin(MAX_W'(bus.data_in)));
  assign step_p0 = bus.in_valid && (bus.mode == MODE_STEP);
  assign load_p0 = bus.in_valid && (bus.mode == MODE_LOAD);

  gray_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .step      (step_p0),
    .load      (load_p0),
    .load_val  (bus.data_in),
    .gray_next (gray_next),
    .cnt_gray  (cnt_gray),
    .cnt_wrap  (cnt_wrap)
  );

  // Result select: counter modes report the counter's new Gray value.
  always_comb begin
    res_p0 = '0;
    case (bus.mode)
      MODE_B2G:  res_p0 = b2g_p0;
      MODE_G2B:  res_p0 = g2b_p0;
      MODE_STEP: res_p0 = gray_next;
      MODE_LOAD: res_p0 = gray_next;
      default:   res_p0 = '0;
    endcase
  end

  // Stage p1: result holds when idle; valid pulses once per accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid) begin
        data_p1 <= res_p0;
      end
    end
  end

  assign bus.data_out  = data_p1;
  assign bus.out_valid = vld_p1;
  assign bus.cnt_gray  = cnt_gray;
  assign bus.cnt_wrap  = cnt_wrap;

endmodule

// File: tb/tb_gray_code.sv
// Directed bench for gray_code (WIDTH = 4).
module tb_gray_code;
  import gray_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  logic [3:0] prev_gray;

  gray_code_if #(.WIDTH(4)) bus ();

  gray_code #(
    .WIDTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gray code of 0..15, written out by hand.
  logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs from a falling edge, return at the next falling edge.
  task automatic apply(input logic v, input mode_e m, input logic [3:0] d);
    bus.in_valid = v;
    bus.mode     = m;
    bus.data_in  = d;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.mode     = MODE_B2G;
    bus.data_in  = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_data", bus.data_out, 4'h0);
    check("rst_vld", bus.out_valid, 1'b0);
    check("rst_cnt", bus.cnt_gray, 4'h0);
    check("rst_wrap", bus.cnt_wrap, 1'b0);
    rst = 1'b0;

    apply(1'b1, MODE_B2G, 4'b1101);
    check("b2g_1101", bus.data_out, 4'b1011);
    check("b2g_1101_vld", bus.out_valid, 1'b1);

    apply(1'b0, MODE_B2G, 4'b0000);
    check("hold_data", bus.data_out, 4'b1011);
    check("hold_vld", bus.out_valid, 1'b0);
    apply(1'b0, MODE_G2B, 4'b0110);
    check("hold_data2", bus.data_out, 4'b1011);
    check("hold_vld2", bus.out_valid, 1'b0);

    apply(1'b1, MODE_G2B, 4'b1011);
    check("g2b_1011", bus.data_out, 4'b1101);
    check("g2b_1011_vld", bus.out_valid, 1'b1);
    apply(1'b1, MODE_B2G, 4'b1111);
    check("b2g_1111", bus.data_out, 4'b1000);
    apply(1'b1, MODE_B2G, 4'b0000);
    check("b2g_0000", bus.data_out, 4'b0000);
    check("b2g_0000_vld", bus.out_valid, 1'b1);

    // Back-to-back round trip of every value.
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, MODE_B2G, 4'(i));
      check($sformatf("rt_b2g_%0d", i), bus.data_out, gray_tab[i]);
      check($sformatf("rt_b2g_vld_%0d", i), bus.out_valid, 1'b1);
    end
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, MODE_G2B, gray_tab[i]);
      check($sformatf("rt_g2b_%0d", i), bus.data_out, 32'(i));
      check($sformatf("rt_g2b_vld_%0d", i), bus.out_valid, 1'b1);
    end
    apply(1'b0, MODE_B2G, 4'h0);
    check("rt_idle_vld", bus.out_valid, 1'b0);
    check("conv_keeps_cnt", bus.cnt_gray, 4'h0);

    // Counter: load, step, step across the wrap.
    apply(1'b1, MODE_LOAD, 4'b1110);
    check("load_cnt", bus.cnt_gray, 4'b1001);
    check("load_data", bus.data_out, 4'b1001);
    check("load_vld", bus.out_valid, 1'b1);
    check("load_nowrap", bus.cnt_wrap, 1'b0);
    prev_gray = bus.cnt_gray;
    apply(1'b1, MODE_STEP, 4'h0);
    check("step1_cnt", bus.cnt_gray, 4'b1000);
    check("step1_data", bus.data_out, 4'b1000);
    check("step1_wrap", bus.cnt_wrap, 1'b0);
    check("step1_onebit", $countones(prev_gray ^ bus.cnt_gray), 1);
    prev_gray = bus.cnt_gray;
    apply(1'b1, MODE_STEP, 4'h0);
    check("step2_cnt", bus.cnt_gray, 4'b0000);
    check("step2_data", bus.data_out, 4'b0000);
    check("step2_wrap", bus.cnt_wrap, 1'b1);
    check("step2_onebit", $countones(prev_gray ^ bus.cnt_gray), 1);
    prev_gray = bus.cnt_gray;
    apply(1'b1, MODE_STEP, 4'h0);
    check("step3_cnt", bus.cnt_gray, 4'b0001);
    check("step3_wrap", bus.cnt_wrap, 1'b0);
    check("step3_onebit", $countones(prev_gray ^ bus.cnt_gray), 1);
    apply(1'b0, MODE_STEP, 4'h0);
    check("idle_cnt", bus.cnt_gray, 4'b0001);
    check("idle_vld", bus.out_valid, 1'b0);
    apply(1'b1, MODE_LOAD, 4'b1111);
    check("load_max_cnt", bus.cnt_gray, 4'b1000);
    check("load_max_nowrap", bus.cnt_wrap, 1'b0);
    apply(1'b1, MODE_B2G, 4'b0011);
    check("conv_after_load_data", bus.data_out, 4'b0010);
    check("conv_after_load_cnt", bus.cnt_gray, 4'b1000);

    // Reset in the middle of a stream discards the request issued with it.
    apply(1'b1, MODE_LOAD, 4'b0101);
    check("pre_rst_cnt", bus.cnt_gray, 4'b0111);
    rst = 1'b1;
    apply(1'b1, MODE_STEP, 4'b1101);
    check("mid_rst_data", bus.data_out, 4'h0);
    check("mid_rst_vld", bus.out_valid, 1'b0);
    check("mid_rst_cnt", bus.cnt_gray, 4'h0);
    check("mid_rst_wrap", bus.cnt_wrap, 1'b0);
    rst = 1'b0;
    apply(1'b0, MODE_B2G, 4'b1101);
    check("post_rst_data", bus.data_out, 4'h0);
    check("post_rst_vld", bus.out_valid, 1'b0);
    check("post_rst_cnt", bus.cnt_gray, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gray_code.md
Name: gray_code

Overview:
- Registered 4-bit (parameterisable) binary/Gray code converter with an integrated Gray-sequence counter.
- Used wherever multi-bit values cross domains or drive position encoders and need single-bit-change encoding.
- One clock. Synchronous, active-high reset. All outputs registered; 1-cycle latency.

Parameters:
- WIDTH, 4, code width in bits; legal range 2..16. Bit WIDTH-1 is the MSB (the "A" bit of the 4-bit case; D is LSB).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  qualifies data_in/mode for conversion this cycle
- mode  input  2  00 = binary->Gray, 01 = Gray->binary, 10 = Gray counter step, 11 = Gray counter load from data_in (binary)
- data_in  input  WIDTH  operand; MSB = A, then B, C, D
- data_out  output  WIDTH  registered result F (F[3] = MSB)
- out_valid  output  1  high one cycle after an accepted in_valid
- cnt_gray  output  WIDTH  current Gray counter value
- cnt_wrap  output  1  one-cycle pulse when counter wraps all-max back to 0

Behaviour:
- Reset (rst=1 at clk edge): data_out=0, out_valid=0, cnt_gray=0, cnt_wrap=0. Reset wins over in_valid in the same cycle.
- Binary->Gray (mode 00): F[WIDTH-1] = in[WIDTH-1]; F[i] = in[i+1] XOR in[i] for i < WIDTH-1.
- Gray->binary (mode 01): B[WIDTH-1] = G[WIDTH-1]; B[i] = B[i+1] XOR G[i]. Prefix-XOR chain, combinational within one cycle.
- Latency: result appears on data_out at the clock edge after in_valid=1. out_valid is asserted for exactly that cycle.
- in_valid=0: data_out holds its last value; out_valid=0.
- Gray counter:
  - Internal binary count register; cnt_gray = registered Gray encoding of that count.
  - Mode 10 with in_valid: count increments by 1 modulo 2^WIDTH. data_out = new Gray value; out_valid=1.
  - Mode 11 with in_valid: count = data_in. cnt_gray and data_out = Gray(data_in) next cycle; out_valid=1.
- Wrap: increment from all-ones binary (Gray 100..0) yields 0 and pulses cnt_wrap for one cycle. No wrap pulse on load.
- Modes 00/01 do not disturb the counter.
- Consecutive cnt_gray values differ in exactly one bit, including across the wrap.
- Back-to-back in_valid every cycle is supported; no stalls and no backpressure.

Decomposition:
- Shared package gray_pkg: mode encodings (MODE_B2G, MODE_G2B, MODE_STEP, MODE_LOAD) as a 2-bit typedef, plus pure functions bin2gray() and gray2bin() parameterised by width.
- One sub-module is natural: gray_counter, holding the count register, Gray output register and wrap pulse. The top level does conversion muxing and output registers.

Test Plan:
- Mode 00, data_in=1101, in_valid 1 cycle -> next cycle data_out=1011 (F[3]=1, F[2]=0, F[1]=1, F[0]=1), out_valid=1.
- Mode 01, data_in=1011 -> data_out=1101. Mode 00 with 1111 -> 1000. Mode 00 with 0000 -> 0000.
- Exhaustive round trip: all 16 values through mode 00, then the results through mode 01 -> original value returned; out_valid high exactly one cycle per request.
- Load 1110 (mode 11) -> cnt_gray=1001. Step (mode 10) -> 1000. Step again -> 0000 with cnt_wrap=1 for one cycle. Each step changes exactly one bit.
- Assert rst during a stream of in_valid requests -> next cycle data_out=0, out_valid=0, cnt_gray=0. Request issued with rst=1 is discarded.
- Hold in_valid=0 after a result -> data_out stays 1011, out_valid=0.
